// File: rtl/sparse_xin_bram_writer_if.sv
// sparse_xin_bram_writer_if: word stream in, BRAM line writes and MxV controller handshake out.
interface sparse_xin_bram_writer_if #(
    parameter int DATA_W = 32,
    parameter int LINE_W = 1024,
    parameter int ADDR_W = 8
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [LINE_W-1:0] bram_din;
    logic              idle;
    logic              dateout_in;
    logic              busy;
    logic              done;
    logic              err_short;

    modport master (
        output s_data, s_valid, s_last, dateout_in,
        input  s_ready, bram_en, bram_we, bram_addr, bram_din, idle, busy, done, err_short
    );

    modport slave (
        input  s_data, s_valid, s_last, dateout_in,
        output s_ready, bram_en, bram_we, bram_addr, bram_din, idle, busy, done, err_short
    );
endinterface

// File: rtl/sparse_xin_bram_writer.sv
// sparse_xin_bram_writer: packs a 32-bit word stream into BRAM lines, kicks the MxV controller
// and waits for its output phase to finish before taking the next frame.
module sparse_xin_bram_writer #(
    parameter int DATA_W   = 32,
    parameter int LINE_W   = 1024,
    parameter int WORDS    = 32,
    parameter int LINES    = 64,
    parameter int ADDR_W   = 8,
    parameter int KICK_CYC = 2
) (
    input logic                     clk,
    input logic                     rst,
    sparse_xin_bram_writer_if.slave bus
);
    localparam int WC_W = $clog2(WORDS);
    localparam int KC_W = $clog2(KICK_CYC + 1);
    localparam logic [WC_W-1:0]   W_LAST = WC_W'(WORDS - 1);
    localparam logic [ADDR_W-1:0] L_LAST = ADDR_W'(LINES - 1);
    localparam logic [KC_W-1:0]   K_LAST = KC_W'(KICK_CYC - 1);

    typedef enum logic [2:0] {IDLE, FILL, WRITE, KICK, WAIT_MXV, DONE} state_t;

    state_t            state_q;
    logic [WC_W-1:0]   wcnt_q;
    logic [ADDR_W-1:0] lcnt_q;
    logic [KC_W-1:0]   kcnt_q;
    logic [LINE_W-1:0] pack_q, pack_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] din_q;
    logic              s_ready_q, bram_en_q, bram_we_q, idle_q, busy_q, done_q, err_q;
    logic              short_q, dout_q;
    logic              acc, line_end, frame_end;

    always_comb begin
        acc       = bus.s_valid && s_ready_q;
        pack_d    = pack_q | (LINE_W'(bus.s_data) << (DATA_W * wcnt_q));
        line_end  = (wcnt_q == W_LAST) || bus.s_last;
        frame_end = (wcnt_q == W_LAST) && (lcnt_q == L_LAST);
    end

    // Outputs are set on the edge entering a state so they are valid for that state's cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            lcnt_q    <= '0;
            kcnt_q    <= '0;
            pack_q    <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            s_ready_q <= 1'b0;
            bram_en_q <= 1'b0;
            bram_we_q <= 1'b0;
            idle_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            short_q   <= 1'b0;
            dout_q    <= 1'b0;
        end else begin
            bram_en_q <= 1'b0;
            bram_we_q <= 1'b0;
            done_q    <= 1'b0;
            dout_q    <= bus.dateout_in;
            case (state_q)
                IDLE, FILL: begin
                    s_ready_q <= 1'b1;
                    if (acc) begin
                        busy_q    <= 1'b1;
                        wcnt_q    <= wcnt_q + 1'b1;
                        pack_q    <= pack_d;
                        state_q   <= line_end ? WRITE : FILL;
                        s_ready_q <= !line_end;
                        if (line_end) begin
                            bram_en_q <= 1'b1;
                            bram_we_q <= 1'b1;
                            addr_q    <= lcnt_q;
                            din_q     <= pack_d;
                        end
                        if (bus.s_last && !frame_end) begin
                            err_q   <= 1'b1;
                            short_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    pack_q <= '0;
                    wcnt_q <= '0;
                    lcnt_q <= (lcnt_q == L_LAST) ? '0 : lcnt_q + 1'b1;
                    if (lcnt_q == L_LAST) begin
                        state_q <= KICK;
                        idle_q  <= 1'b1;
                        kcnt_q  <= '0;
                        short_q <= 1'b0;
                    end else if (short_q) begin
                        // early s_last: flush the remaining lines as zeros, one per cycle
                        bram_en_q <= 1'b1;
                        bram_we_q <= 1'b1;
                        addr_q    <= lcnt_q + 1'b1;
                        din_q     <= '0;
                    end else begin
                        state_q   <= FILL;
                        s_ready_q <= 1'b1;
                    end
                end
                KICK: begin
                    idle_q  <= kcnt_q != K_LAST;
                    kcnt_q  <= kcnt_q + 1'b1;
                    state_q <= (kcnt_q == K_LAST) ? WAIT_MXV : KICK;
                end
                WAIT_MXV: begin
                    if (dout_q && !bus.dateout_in) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    s_ready_q <= 1'b1;
                    err_q     <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.bram_en   = bram_en_q;
    assign bus.bram_we   = bram_we_q;
    assign bus.bram_addr = addr_q;
    assign bus.bram_din  = din_q;
    assign bus.idle      = idle_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err_short = err_q;
endmodule

// File: doc/sparse_xin_bram_writer.md
Name: sparse_xin_bram_writer

Overview:
- Producer-side front end for the sparse MxV engine.
- Accepts the dense input vector x as a 32-bit valid/ready word stream and packs it into 1024-bit lines.
- Writes those lines into the input BRAM that the MxV controller later reads through its input_addr/eninput port.
- Once a full frame is stored, pulses idle to launch the controller, then waits for the controller's dateout to fall (result output finished) before accepting the next frame.

Parameters:
- DATA_W, 32, stream word width.
- LINE_W, 1024, BRAM line width; must equal DATA_W*WORDS.
- WORDS, 32, words packed per line.
- LINES, 64, lines per frame (BRAM addresses 0..LINES-1).
- ADDR_W, 8, BRAM address width.
- KICK_CYC, 2, cycles idle is held high to restart the controller.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- s_data  in  DATA_W  stream word
- s_valid  in  1  word valid
- s_last  in  1  last word of frame (optional marker)
- s_ready  out  1  writer can accept a word
- bram_en  out  1  input BRAM port enable
- bram_we  out  1  input BRAM write enable
- bram_addr  out  ADDR_W  input BRAM write address
- bram_din  out  LINE_W  input BRAM write data
- idle  out  1  start/restart pulse to the MxV controller
- dateout_in  in  1  controller output-phase flag
- busy  out  1  frame in progress (FILL through WAIT_MXV)
- done  out  1  one-cycle pulse when the controller finishes
- err_short  out  1  sticky: frame ended early by s_last

Behaviour:
- Reset is synchronous, active-low, on rst sampled at posedge clk. Reset values:
  - s_ready=0, bram_en=0, bram_we=0, bram_addr=0, bram_din=0, idle=0, busy=0, done=0, err_short=0.
  - State=IDLE; word counter, line counter and pack register are cleared.
- A word is accepted when s_valid and s_ready are both 1 at a clock edge.

States:
- IDLE:
  - s_ready=1; err_short is cleared on entry from DONE.
  - The first accepted word goes to FILL with word count 1 and sets busy=1.
- FILL:
  - s_ready=1.
  - Word k (0-based within the line) is placed at pack[DATA_W*k +: DATA_W]; word 0 occupies the LSBs.
  - Accepting word WORDS-1 moves to WRITE.
- WRITE (exactly 1 cycle):
  - s_ready=0, bram_en=1, bram_we=1, bram_addr=line count, bram_din=pack.
  - Next cycle: pack cleared, line count incremented.
  - If line count was LINES-1, go to KICK; else go to FILL.
  - Write latency: 1 cycle from acceptance of the last word of a line to bram_we=1.
- KICK:
  - idle=1 for KICK_CYC consecutive cycles; bram_en/we=0; s_ready=0. Then go to WAIT_MXV with idle=0.
  - The controller begins its load sequence on the first cycle idle is low.
- WAIT_MXV:
  - s_ready=0.
  - A registered copy of dateout_in is kept; a 1->0 transition of dateout_in moves to DONE.
  - dateout_in held at 0 forever leaves the block waiting; there is no timeout.
- DONE (1 cycle): done=1, busy=0, then go to IDLE.

Boundary conditions:
- Early s_last (accepted before word WORDS-1 of line LINES-1):
  - Set err_short=1.
  - Unfilled words of the current line stay zero; the line is written.
  - Remaining lines up to LINES-1 are written as all-zero, one per cycle in WRITE with s_ready=0.
  - Then proceed to KICK.
- s_last on the final word of the frame: normal; err_short stays 0.
- No s_last on the final word: the frame ends by count; s_last is not required.
- s_valid=0 mid-line: the block holds in FILL indefinitely; partial lines are never written.
- Words presented while s_ready=0 are not consumed; the source must hold them.
- bram_addr holds its last value when bram_en=0.
- bram_addr wraps only via frame end; addresses beyond LINES-1 are never issued.
- Reset mid-frame: all state is discarded immediately and no further BRAM writes occur; a partially written BRAM is left as-is. idle is forced low, so the controller stays in its current state until the next frame's KICK.

Test Plan:
1. Full frame: stream words 0..2047 with values equal to their index, s_valid always 1.
   - 64 writes occur at addr 0..63.
   - Line 0 bits[31:0]=0 and bits[1023:992]=31; line 63 bits[1023:992]=2047.
   - idle=1 for exactly 2 cycles after the addr 63 write.
2. Throughput/latency:
   - s_ready=0 exactly one cycle after each 32nd accepted word.
   - bram_we rises 1 cycle after word 31, 63, and so on.
   - The frame takes 2048+64 cycles to reach KICK.
3. Gapped stream: random s_valid gaps (30% idle).
   - BRAM contents are identical to test 1.
   - No write is issued for a partial line.
4. Short frame: s_last on word 100.
   - err_short=1.
   - Line 3 holds words 96..100 with the upper 27 words zero.
   - Lines 4..63 are written as zero; KICK still occurs.
5. Completion: drive dateout_in 0->1, hold 1026 cycles, then 1->0.
   - done pulses 1 cycle later; busy falls; s_ready=1 on the next cycle.
6. Reset mid-frame: assert rst=0 after word 500.
   - All outputs are 0 next cycle.
   - A following full frame writes from addr 0 with correct data.
